// File: rtl/flash_adc_seq.sv
// Flash ADC conversion sequencer: sample strobe, settle, capture, encode, handshake.
// Optional bubble correction is enabled by defining FLASH_ADC_BUBBLE_CORR_EN.
module flash_adc_seq #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic [31:0] comp_low,
  input  logic        code_ready,
  output logic        sample_en,
  output logic        busy,
  output logic [4:0]  code,
  output logic        code_valid,
  output logic        ovr,
  output logic        under,
  output logic [15:0] conv_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_CAPTURE,
    S_ENCODE,
    S_OUTPUT
  } state_t;

  localparam logic [3:0] SETTLE_LD =
    (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

  state_t      state, state_nx;
  logic [3:0]  settle_cnt;
  logic [31:0] t_q;
  logic [31:0] t_cor;
  logic [4:0]  enc_code;
  logic        xfer;

  assign xfer       = (state == S_OUTPUT) && code_ready;
  assign sample_en  = (state == S_SAMPLE);
  assign busy       = (state != S_IDLE);
  assign code_valid = (state == S_OUTPUT);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_SAMPLE;
      S_SAMPLE:  state_nx = (SETTLE_CYC == 0) ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  if (settle_cnt == 4'd0) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_ENCODE;
      S_ENCODE:  state_nx = S_OUTPUT;
      S_OUTPUT:  if (code_ready) state_nx = cont ? S_SAMPLE : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     settle_cnt <= 4'd0;
    else if (state == S_SAMPLE)  settle_cnt <= SETTLE_LD;
    else if (state == S_SETTLE)  settle_cnt <= settle_cnt - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     t_q <= 32'd0;
    else if (state == S_CAPTURE) t_q <= ~comp_low;
  end

`ifdef FLASH_ADC_BUBBLE_CORR_EN
  // Pad with t[-1]=1 below and t[32]=0 above for the 3-input majority vote
  logic [33:0] t_ext;
  assign t_ext = {1'b0, t_q, 1'b1};
  always_comb begin
    t_cor = '0;
    for (int i = 0; i < 32; i++) begin
      t_cor[i] = (t_ext[i] & t_ext[i+1]) |
                 (t_ext[i+1] & t_ext[i+2]) |
                 (t_ext[i] & t_ext[i+2]);
    end
  end
`else
  assign t_cor = t_q;
`endif

  always_comb begin
    enc_code = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (t_cor[i]) enc_code = 5'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code  <= 5'd0;
      ovr   <= 1'b0;
      under <= 1'b0;
    end else if (state == S_ENCODE) begin
      code  <= enc_code;
      ovr   <= t_cor[31];
      under <= ~(|t_cor);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       conv_cnt <= 16'd0;
    else if (xfer) conv_cnt <= conv_cnt + 16'd1;
  end

endmodule

// File: tb/tb_flash_adc_seq.sv
// Self-checking bench for flash_adc_seq against a thermometer-code reference model.
// Build with FLASH_ADC_BUBBLE_CORR_EN defined to check the bubble-corrected variant.
module tb_flash_adc_seq;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont;
  logic [31:0] comp_low;
  logic        code_ready;
  logic        sample_en;
  logic        busy;
  logic [4:0]  code;
  logic        code_valid;
  logic        ovr;
  logic        under;
  logic [15:0] conv_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  flash_adc_seq #(.SETTLE_CYC(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .comp_low   (comp_low),
    .code_ready (code_ready),
    .sample_en  (sample_en),
    .busy       (busy),
    .code       (code),
    .code_valid (code_valid),
    .ovr        (ovr),
    .under      (under),
    .conv_cnt   (conv_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovr, under, code} from comparator word
  function automatic logic [6:0] model(input logic [31:0] cl);
    logic [31:0] t;
    logic [31:0] c;
    int          hi;
    int          below, above;
    t  = ~cl;
    hi = -1;
`ifdef FLASH_ADC_BUBBLE_CORR_EN
    for (int i = 0; i < 32; i++) begin
      below = (i == 0) ? 1 : int'(t[i-1]);
      above = (i == 31) ? 0 : int'(t[i+1]);
      c[i]  = (below + int'(t[i]) + above) >= 2;
    end
`else
    c = t;
`endif
    for (int i = 0; i < 32; i++) if (c[i]) hi = i;
    return {c[31], (hi < 0), (hi < 0) ? 5'd0 : 5'(hi)};
  endfunction

  function automatic logic [31:0] therm(input int lvl);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) if (i < lvl) t[i] = 1'b1;
    return t;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_sample_en"}, sample_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_code"}, code, 0);
    chk({tag, "_valid"}, code_valid, 0);
    chk({tag, "_ovr"}, ovr, 0);
    chk({tag, "_under"}, under, 0);
    chk({tag, "_cnt"}, conv_cnt, 0);
  endtask

  // One single-shot conversion; hold = ready-low cycles spent in OUTPUT
  task automatic conv(input string tag, input logic [31:0] cl,
                      input int hold);
    int         n;
    logic [6:0] e;
    logic [4:0] c0;
    e = model(cl);
    @(negedge clk);
    comp_low   = cl;
    start      = 1'b1;
    code_ready = 1'b0;
    n = 0;
    while (!code_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_sample_en"}, sample_en, 1);
        start = 1'b0;
      end
      if (n == 2) chk({tag, "_sample_pulse"}, sample_en, 0);
    end
    chk({tag, "_latency"}, n, 4 + S);
    chk({tag, "_code"}, code, e[4:0]);
    chk({tag, "_under"}, under, e[5]);
    chk({tag, "_ovr"}, ovr, e[6]);
    c0 = code;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, code_valid, 1);
      chk({tag, "_hold_code"}, code, c0);
      chk({tag, "_hold_cnt"}, conv_cnt, exp_cnt);
    end
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    exp_cnt    = exp_cnt + 16'd1;
    chk({tag, "_valid_fall"}, code_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_cnt"}, conv_cnt, exp_cnt);
  endtask

  initial begin
    int          p[$];
    int          xf;
    int          lvl;
    logic [31:0] cl;
    logic [6:0]  e;

    rst        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    code_ready = 1'b0;
    comp_low   = 32'hFFFF_FFFF;
    exp_cnt    = 16'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    conv("basic", 32'hFFFF_0000, 0);
    conv("under", 32'hFFFF_FFFF, 0);
    conv("over", 32'h0000_0000, 1);
    conv("bubble", 32'hFFFB_0000, 0);
    conv("stall", 32'hFFFF_FF00, 5);

    // Ready outside OUTPUT must not transfer
    @(negedge clk);
    code_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("ready_idle_cnt", conv_cnt, exp_cnt);
    chk("ready_idle_busy", busy, 0);
    code_ready = 1'b0;

    for (int r = 0; r < 12; r++) begin
      lvl = int'($urandom_range(0, 32));
      cl  = ~therm(lvl);
      if ($urandom_range(0, 1) == 1) cl[$urandom_range(0, 31)] ^= 1'b1;
      conv("rand", cl, int'($urandom_range(0, 3)));
    end

    // Continuous mode with ignored start pulses; cont drops in the 3rd run
    cl = 32'hFFFF_F000;
    e  = model(cl);
    @(negedge clk);
    comp_low   = cl;
    cont       = 1'b1;
    code_ready = 1'b1;
    start      = 1'b1;
    xf = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sample_en) p.push_back(n);
      if (code_valid) begin
        xf++;
        chk("cont_code", code, e[4:0]);
      end
      if (p.size() >= 3) cont = 1'b0;
      start = (n > 1 && p.size() < 3 && busy) ? (n % 2 == 0) : 1'b0;
    end
    code_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd3;
    chk("cont_pulses", p.size(), 3);
    if (p.size() >= 3) begin
      chk("cont_gap1", p[1] - p[0], 4 + S);
      chk("cont_gap2", p[2] - p[1], 4 + S);
    end
    chk("cont_xfers", xf, 3);
    chk("cont_cnt", conv_cnt, exp_cnt);
    chk("cont_idle", busy, 0);

    // Reset during SETTLE abandons the conversion
    @(negedge clk);
    comp_low = 32'h0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_zero("rst_settle");
    exp_cnt = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_valid", code_valid, 0);

    // Counter wrap from 0xFFFF
    force dut.conv_cnt = 16'hFFFF;
    #1 release dut.conv_cnt;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    chk("preset_cnt", conv_cnt, exp_cnt);
    conv("wrap", 32'hFFFF_FFF0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
